mem_fetch_unit: RTL and testbench
=================================

MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8'd255, meaning the number of BUSY cycles without ack before a bus error.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports are listed below.
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- ctl_pc_write, ctl_pc_write_cond, ctl_iord, ctl_mem_read, ctl_mem_write, ctl_ir_write  in  1 each  control-FSM strobes.
- ctl_pc_source  in  2  next-PC select.
- alu_zero  in  1  ALU zero flag.
- alu_result  in  32  combinational ALU output.
- alu_out  in  32  ALUOut register.
- b_reg  in  32  store data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle completion pulse.
- pc  out  32  program counter.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- opcode  out  6  equals ir[31:26].
- stall  out  1  control FSM holds state while high.
- bus_err  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement an FSM with states IDLE, BUSY and ERR.
REQ-005 IDLE: if ctl_mem_read or ctl_mem_write is high, the FSM SHALL latch the following and go to BUSY next edge:
- mem_addr = ctl_iord ? alu_out : pc
- mem_we = ctl_mem_write
- mem_wdata = b_reg
- an ir-load flag = ctl_ir_write
REQ-006 SHALL give ctl_mem_write priority when both strobes are high: one write is performed and no read data is captured.
REQ-007 BUSY: mem_req SHALL be 1. On mem_ack the FSM SHALL drop mem_req at the same edge and go to IDLE. On a read, at that edge mem_rdata SHALL load mdr, and SHALL also load ir if the ir-load flag is set.
REQ-008 stall SHALL equal (IDLE and access requested) or (BUSY and not mem_ack) or ERR. The minimum memory-state duration is 2 cycles.
REQ-009 mem_ack SHALL be ignored in IDLE and ERR.
REQ-010 BUSY SHALL count cycles. When the count reaches ACK_TIMEOUT without mem_ack, the FSM SHALL enter ERR, drop mem_req and set bus_err.
REQ-011 ERR SHALL be exited only by reset.
REQ-012 pc SHALL update at an edge only when (ctl_pc_write or (ctl_pc_write_cond and alu_zero)) and not stall.
REQ-013 next PC SHALL be selected by ctl_pc_source:
- 00: alu_result
- 01: alu_out
- 10: {pc[31:28], ir[25:0], 2'b00}, using the ir value before that edge
- 11: pc unchanged
REQ-014 SHALL compute all address and PC arithmetic modulo 2^32 with no overflow detection; pc wraps 32'hFFFF_FFFC+4 -> 0.
REQ-015 ir SHALL change only per REQ-007. mdr SHALL change only on read acks.

Reset
REQ-016 On rst_n low, immediately regardless of clk:
- FSM = IDLE
- pc = RESET_PC
- ir = 0, mdr = 0
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
- bus_err = 0
- timeout counter = 0
REQ-017 Reset during BUSY SHALL abandon the transaction. An ack arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-018 The state enum, PC_SRC_* encodings (00/01/10/11), OPCODE_W = 6 and DATA_W = 32 SHALL live in shared package mips_mc_pkg.
REQ-019 The request FSM and timeout counter SHALL be sub-module mem_txn_fsm. PC register and next-PC mux SHALL remain in mem_fetch_unit.

Verification
REQ-020 Reset, then fetch: read strobe + ir_write + pc_write, source 00, alu_result = 4, mem_ack after 3 cycles with rdata 32'h8C22_0010. Required response:
- mem_addr = 0
- stall high 3 cycles
- ir = 32'h8C22_0010, opcode = 6'b100011
- pc = 4 at the ack edge
REQ-021 Store then fetch: iord = 1, alu_out = 32'h40, b_reg = 32'hDEAD_BEEF, write strobe, ack next cycle; next cycle read strobe. Required response:
- mem_we = 1, mem_addr = 32'h40, wdata = 32'hDEAD_BEEF
- a new read request issued the following cycle with mem_we = 0
- mdr unchanged
REQ-022 Branch: pc_write_cond, source 01, alu_out = 32'h100. With alu_zero = 0, pc holds. With alu_zero = 1, pc = 32'h100.
REQ-023 Jump: ir = 32'h0800_0010, pc = 32'h1000_0004, source 10, pc_write. Required response: pc = 32'h1000_0040.
REQ-024 Timeout: read strobe, no ack for 255 BUSY cycles. Required response:
- bus_err = 1, mem_req = 0, stall = 1
- a late mem_ack is ignored
- rst_n low clears all of the above

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath: widths, next-PC select
// encodings, memory-transaction state encodings and the latched request bundle.
package mips_mc_pkg;

  localparam int DATA_W   = 32;
  localparam int OPCODE_W = 6;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

  typedef logic [1:0] txn_state_t;

  localparam txn_state_t ST_IDLE = 2'd0;
  localparam txn_state_t ST_BUSY = 2'd1;
  localparam txn_state_t ST_ERR  = 2'd2;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              irLoad;
  } txn_req_t;

endpackage

// File: rtl/mem_fetch_unit_if.sv
// Memory bus between the fetch unit (master) and the memory (slave); mem_ack
// is a single-cycle completion pulse and mem_rdata is valid alongside it.
interface mem_fetch_unit_if;

  logic                            mem_req;
  logic                            mem_we;
  logic [mips_mc_pkg::DATA_W-1:0]  mem_addr;
  logic [mips_mc_pkg::DATA_W-1:0]  mem_wdata;
  logic [mips_mc_pkg::DATA_W-1:0]  mem_rdata;
  logic                            mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_txn_fsm.sv
// Memory request sequencer: latches one access in IDLE, holds the bus request
// in BUSY until ack or timeout, and parks in ERR until reset.
module mem_txn_fsm
  import mips_mc_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  txn_req_t              req_i,
  mem_fetch_unit_if.master      bus,
  output logic                  stall_o,
  output logic                  readDone_o,
  output logic                  irLoad_o,
  output logic                  busErr_o
);

  txn_state_t        state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [8:0]        countNext;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              irLoad_q, irLoad_d;
  logic              busErr_q, busErr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // A ninth bit keeps the timeout compare exact even at ACK_TIMEOUT = 255.
  assign countNext = {1'b0, count_q} + 9'd1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    req_d    = req_q;
    we_d     = we_q;
    irLoad_d = irLoad_q;
    busErr_d = busErr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_BUSY;
          req_d    = 1'b1;
          we_d     = req_i.we;
          addr_d   = req_i.addr;
          wdata_d  = req_i.wdata;
          irLoad_d = req_i.irLoad;
          count_d  = 8'd0;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else if (countNext == {1'b0, ACK_TIMEOUT}) begin
          state_d  = ST_ERR;
          req_d    = 1'b0;
          busErr_d = 1'b1;
          count_d  = countNext[7:0];
        end else begin
          count_d = countNext[7:0];
        end
      end
      ST_ERR: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 8'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      irLoad_q <= 1'b0;
      busErr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      req_q    <= req_d;
      we_q     <= we_d;
      irLoad_q <= irLoad_d;
      busErr_q <= busErr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Stall drops in the ack cycle so the control FSM advances on the same edge.
  assign stall_o    = ((state_q == ST_IDLE) && start_i)
                    || ((state_q == ST_BUSY) && !bus.mem_ack)
                    || (state_q == ST_ERR);
  assign readDone_o = (state_q == ST_BUSY) && bus.mem_ack && !we_q;
  assign irLoad_o   = irLoad_q;
  assign busErr_o   = busErr_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: rtl/mem_fetch_unit.sv
// Multicycle MIPS fetch/memory unit: PC register with next-PC select, IR/MDR
// capture, and a memory transaction sequencer that stalls the control FSM.
module mem_fetch_unit
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctl_pc_write,
  input  logic                ctl_pc_write_cond,
  input  logic                ctl_iord,
  input  logic                ctl_mem_read,
  input  logic                ctl_mem_write,
  input  logic                ctl_ir_write,
  input  logic [1:0]          ctl_pc_source,
  input  logic                alu_zero,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   b_reg,
  mem_fetch_unit_if.master    mem,
  output logic [DATA_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic [DATA_W-1:0]   mdr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                stall,
  output logic                bus_err
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              txnStart;
  txn_req_t          txnReq;
  logic              txnStall;
  logic              readDone;
  logic              irLoad;
  logic              busErr;
  logic              pcEn;

  // A write wins over a simultaneous read: only the write is issued.
  assign txnStart      = ctl_mem_read || ctl_mem_write;
  assign txnReq.we     = ctl_mem_write;
  assign txnReq.addr   = ctl_iord ? alu_out : pc_q;
  assign txnReq.wdata  = b_reg;
  assign txnReq.irLoad = ctl_ir_write;

  mem_txn_fsm #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_txn (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (txnStart),
    .req_i      (txnReq),
    .bus        (mem),
    .stall_o    (txnStall),
    .readDone_o (readDone),
    .irLoad_o   (irLoad),
    .busErr_o   (busErr)
  );

  assign pcEn = (ctl_pc_write || (ctl_pc_write_cond && alu_zero)) && !txnStall;

  // The jump target uses the IR value from before the edge, even if a fetch
  // lands in the IR on that same edge.
  always_comb begin
    pc_d = pc_q;
    if (pcEn) begin
      case (ctl_pc_source)
        PC_SRC_ALU:    pc_d = alu_result;
        PC_SRC_ALUOUT: pc_d = alu_out;
        PC_SRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default:       pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    ir_d  = ir_q;
    mdr_d = mdr_q;
    if (readDone) begin
      mdr_d = mem.mem_rdata;
      if (irLoad) begin
        ir_d = mem.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign mdr     = mdr_q;
  assign opcode  = ir_q[31:26];
  assign stall   = txnStall;
  assign bus_err = busErr;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: a transaction-level model predicts bus
// requests and post-step PC/IR/MDR; a monitor compares them as the DUT acts.
module tb_mem_fetch_unit;
  import mips_mc_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [7:0]  ACK_TIMEOUT = 8'd255;

  typedef struct packed {
    logic rd, wr, iord, irw, pcw, pcwc, zero;
    logic [1:0] src;
    logic [31:0] aluRes, aluOut, bReg;
    int unsigned delay;
  } step_t;

  typedef struct packed {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] pc, ir, mdr;
    int unsigned stallCycles;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctl_pc_write, ctl_pc_write_cond, ctl_iord, ctl_mem_read, ctl_mem_write, ctl_ir_write;
  logic [1:0] ctl_pc_source;
  logic alu_zero;
  logic [31:0] alu_result, alu_out, b_reg;
  logic [31:0] pc, ir, mdr;
  logic [5:0] opcode;
  logic stall, bus_err;

  mem_fetch_unit_if memIf ();

  mem_fetch_unit #(
    .RESET_PC    (RESET_PC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctl_pc_write      (ctl_pc_write),
    .ctl_pc_write_cond (ctl_pc_write_cond),
    .ctl_iord          (ctl_iord),
    .ctl_mem_read      (ctl_mem_read),
    .ctl_mem_write     (ctl_mem_write),
    .ctl_ir_write      (ctl_ir_write),
    .ctl_pc_source     (ctl_pc_source),
    .alu_zero          (alu_zero),
    .alu_result        (alu_result),
    .alu_out           (alu_out),
    .b_reg             (b_reg),
    .mem               (memIf),
    .pc                (pc),
    .ir                (ir),
    .mdr               (mdr),
    .opcode            (opcode),
    .stall             (stall),
    .bus_err           (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  req_t reqQ[$];
  res_t resQ[$];
  logic [31:0] memModel [logic [31:0]];
  logic [31:0] modelPc, modelIr, modelMdr;
  bit monEn = 1'b0;
  bit responderOn = 1'b1;
  bit lateAck = 1'b0;
  int unsigned ackDelay = 0;
  int unsigned busyCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic void modelReset();
    modelPc  = RESET_PC;
    modelIr  = 32'h0;
    modelMdr = 32'h0;
  endfunction

  task automatic clearCtl();
    ctl_pc_write = 0; ctl_pc_write_cond = 0; ctl_iord = 0;
    ctl_mem_read = 0; ctl_mem_write = 0; ctl_ir_write = 0;
    ctl_pc_source = PC_SRC_ALU; alu_zero = 0;
  endtask

  // Predict one control step at transaction level, then drive it and hold the
  // strobes until the DUT lets the control FSM advance.
  task automatic applyStimulus(input step_t s);
    logic [31:0] addr, irOld, data;
    int unsigned stallExp;
    req_t r;
    res_t e;
    bit done;
    irOld = modelIr;
    stallExp = 0;
    if (s.rd || s.wr) begin
      addr = s.iord ? s.aluOut : modelPc;
      r.we = s.wr; r.addr = addr; r.wdata = s.bReg;
      reqQ.push_back(r);
      stallExp = 1 + s.delay;
      if (s.wr) memModel[addr] = s.bReg;
      else begin
        data = memRead(addr);
        modelMdr = data;
        if (s.irw) modelIr = data;
      end
    end
    if (s.pcw || (s.pcwc && s.zero)) begin
      case (s.src)
        2'b00: modelPc = s.aluRes;
        2'b01: modelPc = s.aluOut;
        2'b10: modelPc = {modelPc[31:28], irOld[25:0], 2'b00};
        default: ;
      endcase
    end
    e.pc = modelPc; e.ir = modelIr; e.mdr = modelMdr; e.stallCycles = stallExp;
    resQ.push_back(e);

    ackDelay = s.delay;
    ctl_mem_read = s.rd; ctl_mem_write = s.wr; ctl_iord = s.iord; ctl_ir_write = s.irw;
    ctl_pc_write = s.pcw; ctl_pc_write_cond = s.pcwc; alu_zero = s.zero; ctl_pc_source = s.src;
    alu_result = s.aluRes; alu_out = s.aluOut; b_reg = s.bReg;
    monEn = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) checkOutput("step commit timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    clearCtl();
    monEn = 1'b0;
  endtask

  // Memory responder: acks each request after ackDelay extra BUSY cycles.
  initial begin
    memIf.mem_ack = 1'b0;
    memIf.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      memIf.mem_ack = lateAck;
      if (lateAck) memIf.mem_rdata = 32'hFFFF_FFFF;
      if (!rst_n || !memIf.mem_req) busyCnt = 0;
      else if (responderOn) begin
        if (busyCnt == ackDelay) begin
          memIf.mem_ack = 1'b1;
          memIf.mem_rdata = memRead(memIf.mem_addr);
          busyCnt = 0;
        end else busyCnt++;
      end
    end
  end

  // Monitor: checks each new bus request and the state after each committed step.
  initial begin
    bit prevReq = 1'b0;
    bit commitPending = 1'b0;
    int unsigned stallCnt = 0;
    int unsigned savedStall = 0;
    req_t r;
    res_t e;
    forever begin
      @(negedge clk);
      if (commitPending) begin
        commitPending = 1'b0;
        if (resQ.size() == 0) checkOutput("unexpected commit", 32'd1, 32'd0);
        else begin
          e = resQ.pop_front();
          checkOutput("pc", pc, e.pc);
          checkOutput("ir", ir, e.ir);
          checkOutput("mdr", mdr, e.mdr);
          checkOutput("opcode", {26'd0, opcode}, {26'd0, e.ir[31:26]});
          checkOutput("stall cycles", 32'(savedStall), 32'(e.stallCycles));
          checkOutput("bus_err", {31'd0, bus_err}, 32'd0);
        end
      end
      if (memIf.mem_req && !prevReq) begin
        if (reqQ.size() == 0) checkOutput("unexpected request", 32'd1, 32'd0);
        else begin
          r = reqQ.pop_front();
          checkOutput("req we", {31'd0, memIf.mem_we}, {31'd0, r.we});
          checkOutput("req addr", memIf.mem_addr, r.addr);
          checkOutput("req wdata", memIf.mem_wdata, r.wdata);
        end
      end
      prevReq = memIf.mem_req;
      if (monEn && rst_n) begin
        if (stall) stallCnt++;
        else begin
          commitPending = 1'b1;
          savedStall = stallCnt;
          stallCnt = 0;
        end
      end else stallCnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step_t s;
    clearCtl();
    alu_result = 0; alu_out = 0; b_reg = 0;
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checkOutput("reset pc", pc, RESET_PC);
    checkOutput("reset ir", ir, 32'h0);
    checkOutput("reset mdr", mdr, 32'h0);
    checkOutput("reset mem_req", {31'd0, memIf.mem_req}, 32'd0);
    checkOutput("reset mem_addr", memIf.mem_addr, 32'h0);
    checkOutput("reset bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] fetch after reset");
    memModel[32'h0] = 32'h8C22_0010;
    s = '0; s.rd = 1; s.irw = 1; s.pcw = 1; s.src = PC_SRC_ALU; s.aluRes = 32'd4; s.delay = 2;
    applyStimulus(s);
    checkOutput("fetch ir", ir, 32'h8C22_0010);
    checkOutput("fetch opcode", {26'd0, opcode}, 32'b100011);
    checkOutput("fetch pc", pc, 32'd4);

    $display("[TB] store then fetch");
    s = '0; s.wr = 1; s.iord = 1; s.aluOut = 32'h40; s.bReg = 32'hDEAD_BEEF; s.delay = 0;
    applyStimulus(s);
    checkOutput("store mdr unchanged", mdr, 32'h8C22_0010);
    s = '0; s.rd = 1; s.delay = 1;
    applyStimulus(s);

    $display("[TB] conditional branch");
    s = '0; s.pcw = 1; s.aluRes = 32'h50;
    applyStimulus(s);
    s = '0; s.pcwc = 1; s.src = PC_SRC_ALUOUT; s.aluOut = 32'h100; s.zero = 0;
    applyStimulus(s);
    checkOutput("branch not taken pc", pc, 32'h50);
    s.zero = 1;
    applyStimulus(s);
    checkOutput("branch taken pc", pc, 32'h100);

    $display("[TB] jump");
    memModel[32'h200] = 32'h0800_0010;
    s = '0; s.rd = 1; s.iord = 1; s.irw = 1; s.aluOut = 32'h200;
    applyStimulus(s);
    s = '0; s.pcw = 1; s.aluRes = 32'h1000_0004;
    applyStimulus(s);
    s = '0; s.pcw = 1; s.src = PC_SRC_JUMP;
    applyStimulus(s);
    checkOutput("jump pc", pc, 32'h1000_0040);

    $display("[TB] pc wrap and write-priority");
    s = '0; s.pcw = 1; s.aluRes = 32'hFFFF_FFFC;
    applyStimulus(s);
    s = '0; s.rd = 1; s.irw = 1; s.pcw = 1; s.aluRes = 32'hFFFF_FFFC + 32'd4; s.delay = 1;
    applyStimulus(s);
    checkOutput("wrap pc", pc, 32'h0);
    s = '0; s.rd = 1; s.wr = 1; s.irw = 1; s.iord = 1; s.aluOut = 32'h300; s.bReg = 32'h1234_5678;
    applyStimulus(s);

    $display("[TB] randomized steps");
    for (int i = 0; i < 150; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      s = '0;
      s.rd = (kind <= 4) || (kind == 7);
      s.wr = (kind == 5) || (kind == 6) || (kind == 7);
      s.iord = 1'($urandom_range(0, 1));
      s.irw = 1'($urandom_range(0, 1));
      s.pcw = 1'($urandom_range(0, 1));
      s.pcwc = 1'($urandom_range(0, 1));
      s.zero = 1'($urandom_range(0, 1));
      s.src = 2'($urandom_range(0, 3));
      s.aluRes = ($urandom_range(0, 3) == 0) ? $urandom : modelPc + 32'd4;
      s.aluOut = $urandom;
      s.bReg = $urandom;
      s.delay = $urandom_range(0, 4);
      applyStimulus(s);
    end
    @(negedge clk);
    @(negedge clk);

    $display("[TB] ack timeout");
    responderOn = 1'b0;
    begin
      req_t r;
      r.we = 1'b0; r.addr = modelPc; r.wdata = 32'h0;
      reqQ.push_back(r);
    end
    b_reg = 32'h0; ctl_iord = 0; ctl_mem_read = 1;
    repeat (255) @(posedge clk);
    #1;
    checkOutput("before timeout bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("before timeout mem_req", {31'd0, memIf.mem_req}, 32'd1);
    @(posedge clk); #1;
    checkOutput("timeout bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("timeout mem_req", {31'd0, memIf.mem_req}, 32'd0);
    checkOutput("timeout stall", {31'd0, stall}, 32'd1);
    clearCtl();
    @(negedge clk) lateAck = 1'b1;
    @(negedge clk) lateAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("late ack bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("late ack mem_req", {31'd0, memIf.mem_req}, 32'd0);
    checkOutput("late ack stall", {31'd0, stall}, 32'd1);
    checkOutput("late ack mdr", mdr, modelMdr);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("err reset bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("err reset stall", {31'd0, stall}, 32'd0);
    checkOutput("err reset pc", pc, RESET_PC);
    checkOutput("err reset ir", ir, 32'h0);
    checkOutput("err reset mdr", mdr, 32'h0);
    checkOutput("err reset mem_we", {31'd0, memIf.mem_we}, 32'd0);
    checkOutput("err reset mem_addr", memIf.mem_addr, 32'h0);
    checkOutput("err reset mem_wdata", memIf.mem_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] reset during busy");
    @(posedge clk); #1;
    begin
      req_t r;
      r.we = 1'b0; r.addr = modelPc; r.wdata = 32'h0;
      reqQ.push_back(r);
    end
    ctl_mem_read = 1; ctl_ir_write = 1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("busy reset mem_req", {31'd0, memIf.mem_req}, 32'd0);
    clearCtl();
    @(negedge clk) rst_n = 1'b1;
    lateAck = 1'b1;
    @(negedge clk) lateAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle ack mdr", mdr, 32'h0);
    checkOutput("idle ack ir", ir, 32'h0);
    checkOutput("idle ack mem_req", {31'd0, memIf.mem_req}, 32'd0);
    checkOutput("idle ack stall", {31'd0, stall}, 32'd0);

    responderOn = 1'b1;
    s = '0; s.rd = 1; s.irw = 1; s.pcw = 1; s.aluRes = RESET_PC + 32'd4; s.delay = 3;
    applyStimulus(s);
    @(negedge clk);
    @(negedge clk);
    checkOutput("request queue drained", 32'(reqQ.size()), 32'd0);
    checkOutput("result queue drained", 32'(resQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
